// File: rtl/brainhack_run_ctrl_pkg.sv
// brainhack_run_ctrl_pkg
//   Shared definitions for the brainhack run controller: default widths,
//   controller state encoding and the core instruction set (NOP included).
package brainhack_run_ctrl_pkg;

  localparam int unsigned INSTR_W_DEF = 3;
  localparam int unsigned TAPE_DW_DEF = 8;
  localparam int unsigned TAPE_AW_DEF = 8;
  localparam int unsigned PRG_AW_DEF  = 8;
  localparam int unsigned WDOG_W_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_RUN   = 3'd4,
    ST_DONE  = 3'd5
  } run_state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_INC   = 3'd1,  // +
    OP_DEC   = 3'd2,  // -
    OP_RIGHT = 3'd3,  // >
    OP_LEFT  = 3'd4,  // <
    OP_JZ    = 3'd5,  // [
    OP_JNZ   = 3'd6,  // ]
    OP_OUT   = 3'd7   // .
  } opcode_t;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = OP_NOP;

endpackage

// File: rtl/brainhack_run_ctrl_if.sv
// brainhack_run_ctrl_if
//   Host-side bundle of the run controller.
//   Program stream: i_load_valid / o_load_ready handshake, i_load_instr,
//   i_load_last.  Tape readback: i_rd_valid, i_rd_addr request; o_rd_valid,
//   o_rd_data response one cycle later.
//   master = host, slave = controller.
interface brainhack_run_ctrl_if
  import brainhack_run_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned TAPE_DW = TAPE_DW_DEF,
  parameter int unsigned TAPE_AW = TAPE_AW_DEF
) ();

  logic               i_load_valid;
  logic               o_load_ready;
  logic [INSTR_W-1:0] i_load_instr;
  logic               i_load_last;

  logic               i_rd_valid;
  logic [TAPE_AW-1:0] i_rd_addr;
  logic               o_rd_valid;
  logic [TAPE_DW-1:0] o_rd_data;

  modport master (
    output i_load_valid, i_load_instr, i_load_last, i_rd_valid, i_rd_addr,
    input  o_load_ready, o_rd_valid, o_rd_data
  );

  modport slave (
    input  i_load_valid, i_load_instr, i_load_last, i_rd_valid, i_rd_addr,
    output o_load_ready, o_rd_valid, o_rd_data
  );

endinterface

// File: rtl/brainhack_run_ctrl_tape_arbiter.sv
// tape_arbiter
//   Tape memory port mux selected by controller state.
//   CLEAR: zero-fill at clr_addr.  RUN: core request passes through.
//   DONE: host read address drives the port, no writes.  Otherwise idle.
//   Ports: state, clr_addr, cpu_we/cpu_addr/cpu_data, run_end, rd_addr in;
//   tape_we/tape_addr/tape_wdata out.
module tape_arbiter
  import brainhack_run_ctrl_pkg::*;
#(
  parameter int unsigned TAPE_DW = TAPE_DW_DEF,
  parameter int unsigned TAPE_AW = TAPE_AW_DEF
) (
  input  run_state_t         state,
  input  logic [TAPE_AW-1:0] clr_addr,
  input  logic               cpu_we,
  input  logic [TAPE_AW-1:0] cpu_addr,
  input  logic [TAPE_DW-1:0] cpu_data,
  input  logic               run_end,
  input  logic [TAPE_AW-1:0] rd_addr,
  output logic               tape_we,
  output logic [TAPE_AW-1:0] tape_addr,
  output logic [TAPE_DW-1:0] tape_wdata
);

  always_comb begin
    tape_we    = 1'b0;
    tape_addr  = '0;
    tape_wdata = '0;
    case (state)
      ST_CLEAR: begin
        tape_we   = 1'b1;
        tape_addr = clr_addr;
      end
      ST_RUN: begin
        // In the end cycle the core sits at PC == prog_len, past the
        // program; its request there is not part of the program.
        tape_we    = cpu_we & ~run_end;
        tape_addr  = cpu_addr;
        tape_wdata = cpu_data;
      end
      ST_DONE: tape_addr = rd_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/brainhack_run_ctrl.sv
// brainhack_run_ctrl
//   Job sequencer around the brainhack core: clears the tape, streams a
//   program into program memory, runs the core until PC == prog_len or the
//   watchdog expires, then serves host tape reads.
//   Ports:
//     i_clock, i_reset          clock, synchronous active-high reset
//     i_start, i_abort          job start (IDLE/DONE), abort to IDLE
//     host                      program stream + tape readback bundle
//     o_cpu_run, o_cpu_rst      core enable, one-cycle core clear
//     i_cpu_prgmem_addr         core PC
//     i_cpu_tape_*              core tape write request
//     o_tape_*, i_tape_rdata    tape memory port (async read)
//     o_prg_*                   program memory write port
//     o_busy/done/error/timeout status
module brainhack_run_ctrl
  import brainhack_run_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned TAPE_DW = TAPE_DW_DEF,
  parameter int unsigned TAPE_AW = TAPE_AW_DEF,
  parameter int unsigned PRG_AW  = PRG_AW_DEF,
  parameter int unsigned WDOG_W  = WDOG_W_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  brainhack_run_ctrl_if.slave host,
  output logic               o_cpu_run,
  output logic               o_cpu_rst,
  input  logic [PRG_AW-1:0]  i_cpu_prgmem_addr,
  input  logic               i_cpu_tape_in,
  input  logic [TAPE_AW-1:0] i_cpu_tape_addr,
  input  logic [TAPE_DW-1:0] i_cpu_tape_data,
  output logic               o_tape_we,
  output logic [TAPE_AW-1:0] o_tape_addr,
  output logic [TAPE_DW-1:0] o_tape_wdata,
  input  logic [TAPE_DW-1:0] i_tape_rdata,
  output logic               o_prg_we,
  output logic [PRG_AW-1:0]  o_prg_addr,
  output logic [INSTR_W-1:0] o_prg_wdata,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic               o_timeout
);

  // Last address a program may occupy without its final beat overflowing.
  localparam logic [PRG_AW-1:0] PRG_LAST = {PRG_AW{1'b1}} - PRG_AW'(1);

  run_state_t state, next_state;

  logic [TAPE_AW-1:0] clr_addr;
  logic [PRG_AW-1:0]  load_cnt;
  logic [PRG_AW-1:0]  prog_len;
  logic [WDOG_W-1:0]  wdog;
  logic [WDOG_W-1:0]  wdog_inc;
  logic               error_q;
  logic               timeout_q;
  logic               rd_valid_q;
  logic [TAPE_DW-1:0] rd_data_q;

  logic run_end;
  logic wdog_expire;
  logic load_accept;
  logic host_read;
  logic load_ready;
  logic prg_we;
  logic cpu_run;
  logic cpu_rst;
  logic busy;
  logic done;

  assign run_end     = (i_cpu_prgmem_addr == prog_len);
  assign wdog_inc    = (wdog == '1) ? wdog : wdog + WDOG_W'(1);
  // End takes priority when both happen in the same RUN cycle.
  assign wdog_expire = (wdog_inc == '1) & ~run_end;
  assign load_accept = (state == ST_LOAD) & host.i_load_valid;
  assign host_read   = (state == ST_DONE) & host.i_rd_valid;

  // State register
  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= next_state;
  end

  // Next state and state-decoded outputs
  always_comb begin
    next_state = state;
    load_ready = 1'b0;
    prg_we     = 1'b0;
    cpu_run    = 1'b0;
    cpu_rst    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) next_state = ST_CLEAR;
      end
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_addr == '1) next_state = ST_LOAD;
      end
      ST_LOAD: begin
        busy       = 1'b1;
        load_ready = 1'b1;
        if (host.i_load_valid) begin
          prg_we = ~i_abort;
          if (host.i_load_last)        next_state = ST_START;
          else if (load_cnt == PRG_LAST) next_state = ST_DONE;
        end
      end
      ST_START: begin
        busy       = 1'b1;
        cpu_rst    = 1'b1;
        next_state = ST_RUN;
      end
      ST_RUN: begin
        busy    = 1'b1;
        cpu_run = 1'b1;
        if (run_end || wdog_expire) next_state = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (i_start) next_state = ST_CLEAR;
      end
      default: next_state = ST_IDLE;
    endcase
    if (i_abort) next_state = ST_IDLE;
  end

  // Counters, flags and host read register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      clr_addr   <= '0;
      load_cnt   <= '0;
      prog_len   <= '0;
      wdog       <= '0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= host_read;
      if (host_read) rd_data_q <= i_tape_rdata;

      case (state)
        ST_IDLE: begin
          error_q   <= 1'b0;
          timeout_q <= 1'b0;
          clr_addr  <= '0;
          load_cnt  <= '0;
        end
        ST_DONE: begin
          if (i_start && !i_abort) begin
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            clr_addr  <= '0;
            load_cnt  <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_addr != '1) clr_addr <= clr_addr + TAPE_AW'(1);
        end
        ST_LOAD: begin
          if (load_accept && !i_abort) begin
            if (host.i_load_last)          prog_len <= load_cnt + PRG_AW'(1);
            else if (load_cnt == PRG_LAST) error_q  <= 1'b1;
            else                           load_cnt <= load_cnt + PRG_AW'(1);
          end
        end
        ST_START: wdog <= '0;
        ST_RUN: begin
          if (!i_abort) begin
            wdog <= wdog_inc;
            if (wdog_expire) timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  tape_arbiter #(
    .TAPE_DW (TAPE_DW),
    .TAPE_AW (TAPE_AW)
  ) u_tape_arbiter (
    .state      (state),
    .clr_addr   (clr_addr),
    .cpu_we     (i_cpu_tape_in),
    .cpu_addr   (i_cpu_tape_addr),
    .cpu_data   (i_cpu_tape_data),
    .run_end    (run_end),
    .rd_addr    (host.i_rd_addr),
    .tape_we    (o_tape_we),
    .tape_addr  (o_tape_addr),
    .tape_wdata (o_tape_wdata)
  );

  assign host.o_load_ready = load_ready;
  assign host.o_rd_valid   = rd_valid_q;
  assign host.o_rd_data    = rd_data_q;

  assign o_prg_we    = prg_we;
  assign o_prg_addr  = load_cnt;
  assign o_prg_wdata = prg_we ? host.i_load_instr : '0;
  assign o_cpu_run   = cpu_run;
  assign o_cpu_rst   = cpu_rst;
  assign o_busy      = busy;
  assign o_done      = done;
  assign o_error     = error_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_brainhack_run_ctrl.sv
module tb_brainhack_run_ctrl;
  import brainhack_run_ctrl_pkg::*;

  localparam int unsigned IW = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned PW = 8;
  localparam int unsigned WW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort;
  logic cpu_run, cpu_rst;
  logic [PW-1:0] pc;
  logic cpu_tape_in;
  logic [AW-1:0] cpu_tape_addr;
  logic [DW-1:0] cpu_tape_data;
  logic tape_we;
  logic [AW-1:0] tape_addr;
  logic [DW-1:0] tape_wdata, tape_rdata;
  logic prg_we;
  logic [PW-1:0] prg_addr;
  logic [IW-1:0] prg_wdata;
  logic busy, done, error, timeout;

  brainhack_run_ctrl_if #(.INSTR_W(IW), .TAPE_DW(DW), .TAPE_AW(AW)) host_if ();

  brainhack_run_ctrl #(
    .INSTR_W(IW), .TAPE_DW(DW), .TAPE_AW(AW), .PRG_AW(PW), .WDOG_W(WW)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start), .i_abort(abort),
    .host(host_if),
    .o_cpu_run(cpu_run), .o_cpu_rst(cpu_rst),
    .i_cpu_prgmem_addr(pc),
    .i_cpu_tape_in(cpu_tape_in), .i_cpu_tape_addr(cpu_tape_addr),
    .i_cpu_tape_data(cpu_tape_data),
    .o_tape_we(tape_we), .o_tape_addr(tape_addr), .o_tape_wdata(tape_wdata),
    .i_tape_rdata(tape_rdata),
    .o_prg_we(prg_we), .o_prg_addr(prg_addr), .o_prg_wdata(prg_wdata),
    .o_busy(busy), .o_done(done), .o_error(error), .o_timeout(timeout)
  );

  // Memories: tape preloaded with 0xAA, program memory with NOP
  logic [DW-1:0] tape_mem [2**AW];
  logic [IW-1:0] prg_mem  [2**PW];
  logic mem_init;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 2**AW; i++) tape_mem[i] <= 8'hAA;
      for (int j = 0; j < 2**PW; j++) prg_mem[j] <= OP_NOP;
    end else begin
      if (tape_we) tape_mem[tape_addr] <= tape_wdata;
      if (prg_we)  prg_mem[prg_addr]   <= prg_wdata;
    end
  end
  assign tape_rdata = tape_mem[tape_addr];

  // Behavioural core: one instruction per enabled cycle
  logic [AW-1:0] ptr;
  logic [PW-1:0] stk [16];
  logic [3:0]    sp;
  logic          skip;
  logic [7:0]    depth;
  logic [IW-1:0] cur;

  always_comb begin
    cur           = prg_mem[pc];
    cpu_tape_in   = !skip && (cur == OP_INC || cur == OP_DEC);
    cpu_tape_addr = ptr;
    cpu_tape_data = (cur == OP_DEC) ? tape_rdata - 8'd1 : tape_rdata + 8'd1;
  end

  always @(posedge clk) begin
    if (rst || cpu_rst) begin
      pc <= '0; ptr <= '0; sp <= '0; skip <= 1'b0; depth <= '0;
    end else if (cpu_run) begin
      pc <= pc + 8'd1;
      if (skip) begin
        if (cur == OP_JZ) depth <= depth + 8'd1;
        else if (cur == OP_JNZ) begin
          if (depth == 8'd1) skip <= 1'b0;
          depth <= depth - 8'd1;
        end
      end else begin
        case (opcode_t'(cur))
          OP_RIGHT: ptr <= ptr + 8'd1;
          OP_LEFT:  ptr <= ptr - 8'd1;
          OP_JZ: begin
            if (tape_rdata == 0) begin skip <= 1'b1; depth <= 8'd1; end
            else begin stk[sp] <= pc + 8'd1; sp <= sp + 4'd1; end
          end
          OP_JNZ: begin
            if (tape_rdata != 0) pc <= stk[sp - 4'd1];
            else sp <= sp - 4'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Scoreboard
  int n_vec, n_miss;
  logic [DW-1:0]    rd_q  [$];
  logic [PW+IW-1:0] prg_q [$];
  logic [IW-1:0]    prog_buf [256];
  logic             run_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] status();
    return {busy, done, error, timeout, cpu_run, cpu_rst,
            host_if.o_load_ready, tape_we, prg_we, host_if.o_rd_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_and_clear();
    int writes, bad, guard;
    start = 1'b1;
    tick();
    start = 1'b0;
    writes = 0; bad = 0; guard = 0;
    while (!host_if.o_load_ready && guard < 300) begin
      if (tape_we) begin
        if (tape_addr != AW'(writes) || tape_wdata != 8'h00) bad++;
        writes++;
      end
      tick();
      guard++;
    end
    check("clear_writes", writes, 256);
    check("clear_addr_data", bad, 0);
    check("load_ready_after_clear", host_if.o_load_ready, 1);
    check("no_write_in_load", tape_we, 0);
  endtask

  task automatic load_prog(input int len, input bit with_last, input bit gap);
    int guard;
    for (int i = 0; i < len; i++) begin
      host_if.i_load_valid = 1'b1;
      host_if.i_load_instr = prog_buf[i];
      host_if.i_load_last  = with_last && (i == len - 1);
      prg_q.push_back({PW'(i), prog_buf[i]});
      guard = 0;
      while (!host_if.o_load_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) check("load_ready_wait", guard, 0);
      tick();
      host_if.i_load_valid = 1'b0;
      host_if.i_load_last  = 1'b0;
      if (gap && i != len - 1) tick();
    end
  endtask

  // Called one cycle after the last beat was accepted
  task automatic run_to_done(input int exp_runs, input bit exp_to);
    int runs, guard;
    check("start_cpu_rst", cpu_rst, 1);
    check("start_cpu_run_low", cpu_run, 0);
    tick();
    check("cpu_run_rise", cpu_run, 1);
    runs = 0; guard = 0;
    while (!done && guard < 100) begin
      if (cpu_run) runs++;
      tick();
      guard++;
    end
    check("run_cycles", runs, exp_runs);
    check("done", done, 1);
    check("cpu_run_low_in_done", cpu_run, 0);
    check("busy_low_in_done", busy, 0);
    check("timeout_flag", timeout, exp_to);
    check("error_flag", error, 0);
  endtask

  task automatic rd_req(input int addr, input logic [DW-1:0] exp);
    host_if.i_rd_valid = 1'b1;
    host_if.i_rd_addr  = AW'(addr);
    rd_q.push_back(exp);
    tick();
  endtask

  task automatic rd_idle();
    host_if.i_rd_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic set_inc(input int len);
    for (int i = 0; i < len; i++) prog_buf[i] = OP_INC;
  endtask

  task automatic set_loop();
    prog_buf[0] = OP_INC; prog_buf[1] = OP_JZ; prog_buf[2] = OP_JNZ;
  endtask

  task automatic set_run5();
    prog_buf[0] = OP_INC; prog_buf[1] = OP_INC; prog_buf[2] = OP_INC;
    prog_buf[3] = OP_RIGHT; prog_buf[4] = OP_INC;
  endtask

  initial begin
    n_vec = 0; n_miss = 0; run_seen = 1'b0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; mem_init = 1'b1;
    host_if.i_load_valid = 1'b0; host_if.i_load_instr = '0; host_if.i_load_last = 1'b0;
    host_if.i_rd_valid = 1'b0; host_if.i_rd_addr = '0;

    fork
      forever begin
        @(negedge clk);
        if (cpu_run) run_seen = 1'b1;
        if (host_if.o_rd_valid) begin
          check("rd_expected", rd_q.size() != 0, 1);
          if (rd_q.size() != 0) check("rd_data", host_if.o_rd_data, rd_q.pop_front());
        end
        if (prg_we) begin
          check("prg_expected", prg_q.size() != 0, 1);
          if (prg_q.size() != 0) check("prg_addr_data", {prg_addr, prg_wdata}, prg_q.pop_front());
        end
      end
    join_none

    repeat (3) tick();
    check("reset_status", status(), 0);
    rst = 1'b0; mem_init = 1'b0;
    tick();
    check("idle_status", status(), 0);
    check("idle_rd_data", host_if.o_rd_data, 0);
    check("idle_prg_addr", prg_addr, 0);

    // Clear over a 0xAA tape, trivial program, read every cell back as 0
    start_and_clear();
    prog_buf[0] = OP_NOP;
    load_prog(1, 1'b1, 1'b0);
    run_to_done(2, 1'b0);
    for (int a = 0; a < 256; a++) rd_req(a, 8'h00);
    rd_idle();

    // Overflow: 255 instructions without last
    start_and_clear();
    set_inc(255);
    run_seen = 1'b0;
    load_prog(255, 1'b0, 1'b0);
    check("ovf_done", done, 1);
    check("ovf_error", error, 1);
    check("ovf_timeout", timeout, 0);
    check("ovf_load_ready_low", host_if.o_load_ready, 0);
    tick(); tick();
    check("ovf_never_ran", run_seen, 0);

    // Run "+++>+" with valid toggling every other cycle
    start_and_clear();
    set_run5();
    load_prog(5, 1'b1, 1'b1);
    run_to_done(6, 1'b0);
    rd_req(0, 8'h03);
    rd_req(1, 8'h01);
    rd_req(2, 8'h00);
    rd_idle();

    // Watchdog: "+[]" never ends
    start_and_clear();
    set_loop();
    load_prog(3, 1'b1, 1'b0);
    run_to_done(15, 1'b1);
    rd_req(0, 8'h01);
    rd_idle();

    // End and watchdog expiry in the same cycle
    start_and_clear();
    set_inc(14);
    load_prog(14, 1'b1, 1'b0);
    run_to_done(15, 1'b0);
    rd_req(0, 8'h0E);
    rd_idle();

    // Abort mid-run, then a clean restart
    start_and_clear();
    set_loop();
    load_prog(3, 1'b1, 1'b0);
    check("abort_job_cpu_rst", cpu_rst, 1);
    tick(); tick(); tick();
    check("abort_job_running", cpu_run, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_idle_status", status(), 0);
    host_if.i_rd_valid = 1'b1;
    host_if.i_rd_addr  = '0;
    tick();
    host_if.i_rd_valid = 1'b0;
    check("rd_outside_done", host_if.o_rd_valid, 0);
    start_and_clear();
    set_run5();
    load_prog(5, 1'b1, 1'b0);
    run_to_done(6, 1'b0);
    rd_req(0, 8'h03);
    rd_req(1, 8'h01);
    rd_idle();

    check("rd_q_drained", rd_q.size(), 0);
    check("prg_q_drained", prg_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
